// File: rtl/i2c_bus_requester.sv
// i2c_bus_requester
// -----------------
// Master-side agent between one client (LCD driver or sensor reader) and the
// two-master I2C bus arbiter. It accepts one register-access command, requests
// the bus, and once granted sequences a byte-level I2C master core through a
// register write (pointer byte + data byte) or a register read (pointer byte +
// repeated-start read byte). It then pulses `done` to the arbiter and returns
// the result to the client.
//
// Handshakes:
//   cmd_*  : a command transfers on a rising edge where cmd_valid & cmd_ready.
//            cmd_ready is high only while idle and never in the DONE cycle.
//   rsp_*  : rsp_valid is a one-cycle strobe with no back-pressure; rsp_rdata
//            and rsp_err are meaningful only in that cycle.
//   req/grant/done : req is held from the cycle after acceptance until the
//            transaction finishes; done pulses for one cycle together with
//            rsp_valid, always right after a cycle with req high.
//   i2c_*  : the core latches {i2c_addr, i2c_rw, i2c_data_wr} while i2c_ena is
//            high; a rising edge of i2c_busy means one byte command was taken.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/rw/addr/reg/wdata   client command
//   rsp_valid/rdata/err       client response
//   req, grant, done          arbiter interface
//   i2c_ena/addr/rw/data_wr   master-core command (registered)
//   i2c_busy/data_rd/ack_error  master-core status
//
// State encoding (3 bits, for probing): 0 IDLE, 1 REQ, 2 CMD1, 3 CMD2, 4 FIN,
// 5 DONE.

module i2c_bus_requester #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CW             = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       req,
    input  logic       grant,
    output logic       done,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_data_wr,
    input  logic       i2c_busy,
    input  logic [7:0] i2c_data_rd,
    input  logic       i2c_ack_error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CMD1 = 3'd2,
        S_CMD2 = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state;
    logic          busy_q;
    logic [CW-1:0] timer;
    logic          rw_q;
    logic [6:0]    addr_q;
    logic [7:0]    reg_q;
    logic [7:0]    wdata_q;
    logic          err_q;

    logic rise;
    logic fall;
    logic active;
    logic tmo;
    logic err_now;

    assign rise   = i2c_busy & ~busy_q;
    assign fall   = ~i2c_busy & busy_q;
    assign active = (state == S_CMD1) || (state == S_CMD2) || (state == S_FIN);
    assign tmo    = active && (timer == CW'(TIMEOUT_CYCLES));
    // Sticky error including anything observed in the current cycle, so the
    // value reported at DONE also covers a NACK seen on the final edge.
    assign err_now = err_q | (active & (i2c_ack_error | ~grant | tmo));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            timer       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            req         <= 1'b0;
            done        <= 1'b0;
            i2c_ena     <= 1'b0;
            i2c_addr    <= '0;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= '0;
        end else begin
            busy_q    <= i2c_busy;
            done      <= 1'b0;
            rsp_valid <= 1'b0;

            // Watchdog: restarts on any busy edge, so it bounds the gap
            // between core events rather than the whole transaction.
            if (active) begin
                timer <= (rise || fall) ? '0 : timer + 1'b1;
                err_q <= err_now;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        rw_q      <= cmd_rw;
                        addr_q    <= cmd_addr;
                        reg_q     <= cmd_reg;
                        wdata_q   <= cmd_wdata;
                        err_q     <= 1'b0;
                        req       <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= S_REQ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (grant) begin
                        i2c_ena     <= 1'b1;
                        i2c_rw      <= 1'b0;
                        i2c_addr    <= addr_q;
                        i2c_data_wr <= reg_q;
                        timer       <= '0;
                        state       <= S_CMD1;
                    end
                end

                S_CMD1, S_CMD2, S_FIN: begin
                    if (!grant || tmo) begin
                        // Abort: release the core and report the failure.
                        i2c_ena   <= 1'b0;
                        req       <= 1'b0;
                        done      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= S_DONE;
                    end else if (state == S_CMD1) begin
                        if (rise) begin
                            // rw=1 on the second byte makes the core issue a
                            // repeated start for the read.
                            i2c_rw <= rw_q;
                            if (!rw_q) begin
                                i2c_data_wr <= wdata_q;
                            end
                            state <= S_CMD2;
                        end
                    end else if (state == S_CMD2) begin
                        if (rise) begin
                            // Dropping ena lets the core STOP after this byte.
                            i2c_ena <= 1'b0;
                            state   <= S_FIN;
                        end
                    end else begin
                        if (fall) begin
                            req       <= 1'b0;
                            done      <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err_now;
                            rsp_rdata <= rw_q ? i2c_data_rd : 8'h00;
                            state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
